// File: rtl/alu_pkg.sv
// Shared constants and state type for the 7-bit ALU inverse unit.
// Optional self-check hardware is enabled by ALU_INV_CHECK_EN.
package alu_pkg;
  localparam int ALU_W = 7;
  localparam int ALU_SH_W = 3;
  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  typedef enum logic [1:0] {
    IDLE,
    ROT,
    DONE
  } state_t;
endpackage

// File: rtl/alu_inv_fwd_chk.sv
// Forward NOT/ROR re-application and compare against the captured result.
// Only instantiated when ALU_INV_CHECK_EN is defined.
module alu_inv_fwd_chk
  import alu_pkg::*;
#(
  parameter int W = ALU_W,
  parameter int SH_W = ALU_SH_W
) (
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    r,
  input  logic [SH_W-1:0] n,
  input  logic [1:0]      op,
  output logic            err
);

  logic [W-1:0] fwd;
  logic         bad;

  // re-apply the forward op; an invalid op always flags an error
  always_comb begin
    fwd = '0;
    bad = 1'b1;
    unique case (1'b1)
      op == OP_NOT: begin
        fwd = ~a;
        bad = 1'b0;
      end
      op == OP_ROR: begin
        fwd = a;
        for (int i = 0; i < W - 1; i++) begin
          if (i < int'(n)) begin
            fwd = {fwd[0], fwd[W-1:1]};
          end
        end
        bad = 1'b0;
      end
      default: begin
        fwd = '0;
        bad = 1'b1;
      end
    endcase
    err = bad | (fwd != r);
  end

endmodule

// File: rtl/alu_inv_seq.sv
// Sequential inverse unit: recovers operand A from an ALU NOT/ROR result.
// Define ALU_INV_CHECK_EN to add the registered chk_err self-check output.
module alu_inv_seq
  import alu_pkg::*;
#(
  parameter int W = ALU_W,
  parameter int SH_W = ALU_SH_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_r,
  input  logic [SH_W-1:0] in_b,
  input  logic [1:0]      in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_a,
  output logic            out_cf,
  output logic            out_sf,
`ifdef ALU_INV_CHECK_EN
  output logic            out_zf,
  output logic            chk_err
`else
  output logic            out_zf
`endif
);

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]    work;
  logic [SH_W-1:0] cnt;
  logic [SH_W-1:0] n;
  logic [W-1:0]    rot;
  logic [W-1:0]    a_nx;
  logic            cf_nx;
  logic            ld;
  logic            acc;
  logic            is_ror;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign acc       = in_valid & in_ready;
  assign n         = SH_W'(int'(in_b) % W);
  assign rot       = {work[W-2:0], work[W-1]};
  assign is_ror    = (in_op == OP_ROR);

  // next state and the value to load into the result registers
  always_comb begin
    state_nx = state;
    a_nx     = out_a;
    cf_nx    = out_cf;
    ld       = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) begin
          unique case (1'b1)
            in_op == OP_NOT: begin
              a_nx     = ~in_r;
              cf_nx    = 1'b0;
              ld       = 1'b1;
              state_nx = DONE;
            end
            is_ror && (n == '0): begin
              a_nx     = in_r;
              cf_nx    = 1'b0;
              ld       = 1'b1;
              state_nx = DONE;
            end
            is_ror && (n != '0): begin
              state_nx = ROT;
            end
            default: begin
              a_nx     = '0;
              cf_nx    = 1'b0;
              ld       = 1'b1;
              state_nx = DONE;
            end
          endcase
        end
      end
      ROT: begin
        if (cnt == SH_W'(1)) begin
          a_nx     = rot;
          cf_nx    = rot[0];
          ld       = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // rotate working register and step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
    end else if (acc) begin
      work <= in_r;
      cnt  <= n;
    end else if (state == ROT) begin
      work <= rot;
      cnt  <= cnt - SH_W'(1);
    end
  end

  // result and flags are loaded together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a  <= '0;
      out_cf <= 1'b0;
      out_sf <= 1'b0;
      out_zf <= 1'b1;
    end else if (ld) begin
      out_a  <= a_nx;
      out_cf <= cf_nx;
      out_sf <= a_nx[W-1];
      out_zf <= ~|a_nx;
    end
  end

`ifdef ALU_INV_CHECK_EN
  logic [W-1:0]    r_q;
  logic [SH_W-1:0] n_q;
  logic [1:0]      op_q;
  logic [W-1:0]    chk_r;
  logic [SH_W-1:0] chk_n;
  logic [1:0]      chk_op;
  logic            err;

  assign chk_r  = in_ready ? in_r : r_q;
  assign chk_n  = in_ready ? n : n_q;
  assign chk_op = in_ready ? in_op : op_q;

  // capture the request so the check can run at the final rotate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= '0;
      n_q  <= '0;
      op_q <= '0;
    end else if (acc) begin
      r_q  <= in_r;
      n_q  <= n;
      op_q <= in_op;
    end
  end

  alu_inv_fwd_chk #(
    .W    (W),
    .SH_W (SH_W)
  ) u_chk (
    .a   (a_nx),
    .r   (chk_r),
    .n   (chk_n),
    .op  (chk_op),
    .err (err)
  );

  // check flag is registered alongside the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (ld) begin
      chk_err <= err;
    end
  end
`endif

endmodule

// File: doc/alu_inv_seq.md
Name: alu_inv_seq

Overview:
Sequential inverse unit for the 7-bit ALU. It takes an ALU result R with the original OP and B, and recovers operand A.
- OP=NOT: inverted back in one cycle.
- OP=ROR: undone by an iterative rotate-left, one bit per cycle.
- Sits downstream of the ALU in datapath self-test and undo paths.
- Uses valid/ready handshakes on both input and output.

Parameters:
- W, 7, data width (R, result).
- SH_W, 3, shift-amount width; 2**SH_W >= W required.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input request valid.
- in_ready  out  1  unit can accept a request.
- in_r  in  W  ALU result to invert.
- in_b  in  SH_W  original rotate amount.
- in_op  in  2  original op: 00 NOT, 01 ROR, others invalid.
- out_valid  out  1  result valid, held until consumed.
- out_ready  in  1  downstream accepts result.
- out_a  out  W  recovered operand.
- out_cf  out  1  last bit rotated out (ROL), else 0.
- out_sf  out  1  out_a[W-1].
- out_zf  out  1  out_a == 0.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - in_ready=1 after release.
  - out_valid=0, out_a=0, out_cf=0, out_sf=0, out_zf=1.
  - Aborts any operation in progress; no partial result is ever presented.
- States: IDLE, ROT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready the request is accepted at that edge; n = in_b mod W.
  - op=00: out_a <= ~in_r, cf=0, go to DONE (latency 1).
  - op=01, n=0: out_a <= in_r, cf=0, go to DONE (latency 1).
  - op=01, n>0: work <= in_r, cnt <= n, go to ROT.
  - op=10/11: out_a <= 0, cf=0, go to DONE (latency 1).
- ROT:
  - in_ready=0.
  - Each edge: work <= {work[W-2:0], work[W-1]}, cnt <= cnt-1.
  - At cnt==1 the final rotate is written to out_a with cf = rotated value bit 0 (bit moved MSB→LSB), then go to DONE.
  - Total latency for op=01 is 1+n cycles from the accept edge.
- DONE:
  - out_valid=1; out_a and flags held stable.
  - On out_ready, go to IDLE next edge.
  - in_ready=0; in_valid ignored.
  - Throughput: one request per latency+1 cycles minimum; no overlap of input and output.
- Flags: registered together with out_a. sf = out_a[W-1]; zf = ~|out_a.
- Changes to in_* after acceptance have no effect.
- B=7 (≥W) wraps via mod W, matching the ALU's B%7 rotate semantics.

Optional Feature:
- Macro ALU_INV_CHECK_EN.
- Defined:
  - Adds output chk_err (1 bit), registered, valid with out_valid.
  - Re-applies the forward op (NOT, or ROR by n) to out_a and compares with the captured in_r.
  - chk_err=1 on mismatch; for invalid op chk_err=1.
  - Reset value 0.
- Undefined: port and logic absent; no other behaviour changes.

Decomposition:
- Shared package alu_pkg:
  - OP code constants OP_NOT=2'b00, OP_ROR=2'b01.
  - Width constant ALU_W=7.
  - State enum {IDLE, ROT, DONE}.
- Natural sub-module alu_inv_fwd_chk: combinational forward NOT/ROR plus compare, instantiated only under ALU_INV_CHECK_EN.
- Rotate step and counter stay inline.

Test Plan:
- ROL basic:
  - Stimulus: in_op=01, in_r=7'h41, in_b=1.
  - Response: out_valid 2 cycles after accept; out_a=7'h03, cf=1, sf=0, zf=0.
- Multi-step:
  - Stimulus: in_op=01, in_r=7'h01, in_b=5.
  - Response: out_valid after 6 cycles; out_a=7'h20, cf=0; in_ready=0 throughout.
- Wrap and NOT:
  - Stimulus: in_op=01, in_r=7'h55, in_b=7.
  - Response: out_a=7'h55, cf=0, latency 1.
  - Stimulus: in_op=00, in_r=7'h7F.
  - Response: out_a=0, zf=1, sf=0, cf=0, latency 1.
- Back-pressure:
  - Stimulus: out_ready low for 3 cycles while DONE; toggle in_valid/in_r during that time.
  - Response: out_a and flags stable; no new accept; IDLE reached one edge after out_ready=1.
- Reset mid-ROT:
  - Stimulus: assert rst_n=0 asynchronously during the 3rd cycle of a b=5 rotate.
  - Response: out_valid drops immediately; outputs at reset values; in_ready=1 after release; next request completes correctly.
- Invalid op:
  - Stimulus: in_op=10, in_r=7'h2A.
  - Response: out_a=0, zf=1, cf=0, latency 1. With ALU_INV_CHECK_EN, chk_err=1.
